// File: rtl/tc_pl_bus_buff_v2_pkg.sv
// Shared bit positions for the GP0 status and soft-clear vectors of the SPI buffer.
// Latency: none (constants only).
// Backpressure: not applicable.
package tc_pl_bus_buff_v2_pkg;

    // gp0_clr bit positions
    localparam int CLR_TX = 0;
    localparam int CLR_RX = 1;

    // gp0_stat bit positions
    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_AEMPTY = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_AFULL  = 3;
    localparam int STAT_TX_OVF    = 4;
    localparam int STAT_TX_UDF    = 5;
    localparam int STAT_RX_OVF    = 6;
    localparam int STAT_RX_UDF    = 7;

endpackage

// File: rtl/tc_pl_bus_buff_v2_sync_fifo.sv
// Single-clock standard (non-FWFT) FIFO with thresholds and sticky overflow/underflow flags.
// Latency: accepted read returns dout with a one-cycle valid pulse on the next cycle.
// Backpressure: writes while full are dropped (ovf) unless a read frees a slot; reads while empty return nothing (udf).
module tc_pl_bus_buff_v2_sync_fifo #(
    parameter int DW        = 9,
    parameter int AW        = 9,
    parameter int AFULL_TH  = 480,
    parameter int AEMPTY_TH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic          ovf,
    output logic          udf
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_C   = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C  = (AW + 1)'(AEMPTY_TH);

    // Threshold sanity: afull must be reachable and sit above aempty.
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("tc_pl_bus_buff_v2_sync_fifo: AFULL_TH exceeds FIFO depth");
    end
    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_aempty
        $error("tc_pl_bus_buff_v2_sync_fifo: AEMPTY_TH must be below AFULL_TH");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok;
    logic          wr_ok;

    // Flags come from the registered count, so they lag the access by one cycle.
    assign full   = (cnt == DEPTH_C);
    assign empty  = (cnt == '0);
    assign afull  = (cnt >= AFULL_C);
    assign aempty = (cnt <= AEMPTY_C);

    // A read frees a slot, so a full FIFO still takes a write paired with a read.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count, registered read port and sticky flags; soft clear beats any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            valid <= rd_ok;
            if (rd_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            cnt <= cnt + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            if (wr && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_pl_bus_buff_v2.sv
// Dual-channel SPI buffer: TX (GP0 -> SPI engine) and RX (SPI engine -> GP0) FIFOs plus packed status.
// Latency: read data and valid one cycle after an accepted read; flags one cycle after the access.
// Backpressure: full/almost-full and empty/almost-empty exported; misuse is dropped and latched as ovf/udf.
module tc_pl_bus_buff_v2
    import tc_pl_bus_buff_v2_pkg::*;
#(
    parameter int DW        = 9,
    parameter int AW        = 9,
    parameter int AFULL_TH  = 480,
    parameter int AEMPTY_TH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    gp0_clr,
    input  logic [DW-1:0] gp0_wdata,
    input  logic          gp0_wr,
    input  logic          gp0_rd,
    output logic [DW-1:0] gp0_rdata,
    output logic          gp0_rvalid,
    output logic [AW:0]   gp0_tx_cnt,
    output logic [AW:0]   gp0_rx_cnt,
    output logic [7:0]    gp0_stat,
    input  logic          txb_req,
    output logic [DW-1:0] txb_data,
    output logic          txb_valid,
    output logic          txb_empty,
    output logic          txb_aempty,
    input  logic [DW-1:0] rxb_data,
    input  logic          rxb_valid,
    output logic          rxb_full,
    output logic          rxb_afull
);

    logic tx_full, tx_afull, tx_ovf, tx_udf;
    logic rx_empty, rx_aempty, rx_ovf, rx_udf;
    logic unused_flags;

    // TX thresholds above aempty and RX below afull have no consumer.
    assign unused_flags = tx_afull ^ rx_aempty;

    tc_pl_bus_buff_v2_sync_fifo #(
        .DW(DW), .AW(AW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .clr    (gp0_clr[CLR_TX]),
        .wr     (gp0_wr),
        .din    (gp0_wdata),
        .rd     (txb_req),
        .dout   (txb_data),
        .valid  (txb_valid),
        .cnt    (gp0_tx_cnt),
        .full   (tx_full),
        .empty  (txb_empty),
        .afull  (tx_afull),
        .aempty (txb_aempty),
        .ovf    (tx_ovf),
        .udf    (tx_udf)
    );

    tc_pl_bus_buff_v2_sync_fifo #(
        .DW(DW), .AW(AW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .clr    (gp0_clr[CLR_RX]),
        .wr     (rxb_valid),
        .din    (rxb_data),
        .rd     (gp0_rd),
        .dout   (gp0_rdata),
        .valid  (gp0_rvalid),
        .cnt    (gp0_rx_cnt),
        .full   (rxb_full),
        .empty  (rx_empty),
        .afull  (rxb_afull),
        .aempty (rx_aempty),
        .ovf    (rx_ovf),
        .udf    (rx_udf)
    );

    // Pack both channels' flags into the GP0 status word.
    always_comb begin
        gp0_stat                 = '0;
        gp0_stat[STAT_TX_FULL]   = tx_full;
        gp0_stat[STAT_TX_AEMPTY] = txb_aempty;
        gp0_stat[STAT_RX_EMPTY]  = rx_empty;
        gp0_stat[STAT_RX_AFULL]  = rxb_afull;
        gp0_stat[STAT_TX_OVF]    = tx_ovf;
        gp0_stat[STAT_TX_UDF]    = tx_udf;
        gp0_stat[STAT_RX_OVF]    = rx_ovf;
        gp0_stat[STAT_RX_UDF]    = rx_udf;
    end

endmodule

// File: tb/tb_tc_pl_bus_buff_v2.sv
module tb_tc_pl_bus_buff_v2;

    localparam int DW    = 9;
    localparam int AW    = 4;
    localparam int AFT   = 12;
    localparam int AET   = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    gp0_clr = 2'b00;
    logic [DW-1:0] gp0_wdata = '0;
    logic          gp0_wr = 1'b0;
    logic          gp0_rd = 1'b0;
    logic [DW-1:0] gp0_rdata;
    logic          gp0_rvalid;
    logic [AW:0]   gp0_tx_cnt;
    logic [AW:0]   gp0_rx_cnt;
    logic [7:0]    gp0_stat;
    logic          txb_req = 1'b0;
    logic [DW-1:0] txb_data;
    logic          txb_valid;
    logic          txb_empty;
    logic          txb_aempty;
    logic [DW-1:0] rxb_data = '0;
    logic          rxb_valid = 1'b0;
    logic          rxb_full;
    logic          rxb_afull;

    tc_pl_bus_buff_v2 #(.DW(DW), .AW(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
        .clk        (clk),
        .rst        (rst),
        .gp0_clr    (gp0_clr),
        .gp0_wdata  (gp0_wdata),
        .gp0_wr     (gp0_wr),
        .gp0_rd     (gp0_rd),
        .gp0_rdata  (gp0_rdata),
        .gp0_rvalid (gp0_rvalid),
        .gp0_tx_cnt (gp0_tx_cnt),
        .gp0_rx_cnt (gp0_rx_cnt),
        .gp0_stat   (gp0_stat),
        .txb_req    (txb_req),
        .txb_data   (txb_data),
        .txb_valid  (txb_valid),
        .txb_empty  (txb_empty),
        .txb_aempty (txb_aempty),
        .rxb_data   (rxb_data),
        .rxb_valid  (rxb_valid),
        .rxb_full   (rxb_full),
        .rxb_afull  (rxb_afull)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each channel is a queue of words plus sticky flags and last read result.
    int tq[$];
    int rq[$];
    int e_tx_dout, e_rx_dout;
    bit e_tx_val, e_rx_val, e_tx_ovf, e_tx_udf, e_rx_ovf, e_rx_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tq.delete();
        rq.delete();
        e_tx_dout = 0; e_rx_dout = 0;
        e_tx_val = 0; e_rx_val = 0;
        e_tx_ovf = 0; e_tx_udf = 0; e_rx_ovf = 0; e_rx_udf = 0;
    endtask

    // Apply one clock edge's worth of requests to the model (inputs are still stable here).
    task automatic model_edge();
        bit full, empty, rok, wok;
        if (gp0_clr[0]) begin
            tq.delete();
            e_tx_dout = 0; e_tx_val = 0; e_tx_ovf = 0; e_tx_udf = 0;
        end else begin
            full  = (tq.size() == DEPTH);
            empty = (tq.size() == 0);
            rok   = txb_req && !empty;
            wok   = gp0_wr && (!full || rok);
            e_tx_val = rok;
            if (rok) e_tx_dout = tq.pop_front();
            if (wok) tq.push_back(int'(gp0_wdata));
            if (gp0_wr && !wok) e_tx_ovf = 1;
            if (txb_req && empty) e_tx_udf = 1;
        end
        if (gp0_clr[1]) begin
            rq.delete();
            e_rx_dout = 0; e_rx_val = 0; e_rx_ovf = 0; e_rx_udf = 0;
        end else begin
            full  = (rq.size() == DEPTH);
            empty = (rq.size() == 0);
            rok   = gp0_rd && !empty;
            wok   = rxb_valid && (!full || rok);
            e_rx_val = rok;
            if (rok) e_rx_dout = rq.pop_front();
            if (wok) rq.push_back(int'(rxb_data));
            if (rxb_valid && !wok) e_rx_ovf = 1;
            if (gp0_rd && empty) e_rx_udf = 1;
        end
    endtask

    task automatic check_all(input string ph);
        logic [7:0] st;
        st = {e_rx_udf, e_rx_ovf, e_tx_udf, e_tx_ovf,
              rq.size() >= AFT, rq.size() == 0, tq.size() <= AET, tq.size() == DEPTH};
        chk({ph, ":txb_data"},   32'(txb_data),   32'(e_tx_dout));
        chk({ph, ":txb_valid"},  32'(txb_valid),  32'(e_tx_val));
        chk({ph, ":gp0_rdata"},  32'(gp0_rdata),  32'(e_rx_dout));
        chk({ph, ":gp0_rvalid"}, 32'(gp0_rvalid), 32'(e_rx_val));
        chk({ph, ":tx_cnt"},     32'(gp0_tx_cnt), 32'(tq.size()));
        chk({ph, ":rx_cnt"},     32'(gp0_rx_cnt), 32'(rq.size()));
        chk({ph, ":stat"},       32'(gp0_stat),   32'(st));
        chk({ph, ":txb_empty"},  32'(txb_empty),  32'(tq.size() == 0));
        chk({ph, ":txb_aempty"}, 32'(txb_aempty), 32'(tq.size() <= AET));
        chk({ph, ":rxb_full"},   32'(rxb_full),   32'(rq.size() == DEPTH));
        chk({ph, ":rxb_afull"},  32'(rxb_afull),  32'(rq.size() >= AFT));
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        // Reset state
        #3;
        model_reset();
        check_all("reset");
        chk("reset_stat", 32'(gp0_stat), 32'h0000_0006);
        #10 rst = 1'b1;

        // 1: fill TX with 0x001..0x010
        gp0_wr = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            gp0_wdata = DW'(i);
            cyc("t1_wr");
        end
        gp0_wr = 1'b0;
        chk("t1_full", 32'(gp0_stat[0]), 32'd1);
        chk("t1_cnt", 32'(gp0_tx_cnt), 32'd16);

        // 2: overflow while full, no read
        gp0_wr = 1'b1;
        gp0_wdata = 9'h1FF;
        cyc("t2_ovf");
        gp0_wr = 1'b0;
        chk("t2_ovf_flag", 32'(gp0_stat[4]), 32'd1);
        chk("t2_cnt", 32'(gp0_tx_cnt), 32'd16);

        // 1 (cont.): drain TX in order, overflow word must not appear
        txb_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc("t1_rd");
            chk("t1_rd_data", 32'(txb_data), 32'(i));
            chk("t1_rd_valid", 32'(txb_valid), 32'd1);
        end
        txb_req = 1'b0;
        cyc("t1_done");
        chk("t1_valid_drop", 32'(txb_valid), 32'd0);

        // 3: RX empty, simultaneous write and read
        rxb_valid = 1'b1;
        rxb_data  = 9'h0AA;
        gp0_rd    = 1'b1;
        cyc("t3_wr_rd");
        chk("t3_cnt", 32'(gp0_rx_cnt), 32'd1);
        chk("t3_udf", 32'(gp0_stat[7]), 32'd1);
        chk("t3_rvalid", 32'(gp0_rvalid), 32'd0);
        rxb_valid = 1'b0;
        cyc("t3_rd");
        chk("t3_rdata", 32'(gp0_rdata), 32'h0AA);
        chk("t3_rvalid2", 32'(gp0_rvalid), 32'd1);
        gp0_rd = 1'b0;

        // 4: RX full, simultaneous write and read
        rxb_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rxb_data = DW'($urandom_range(0, 511));
            cyc("t4_fill");
        end
        rxb_data = 9'h155;
        gp0_rd = 1'b1;
        cyc("t4_both");
        chk("t4_cnt", 32'(gp0_rx_cnt), 32'd16);
        chk("t4_no_ovf", 32'(gp0_stat[6]), 32'd0);
        rxb_valid = 1'b0;
        gp0_rd = 1'b0;

        // 5: soft clear TX while RX holds data
        gp0_clr = 2'b10;
        cyc("t5_rxclr");
        gp0_clr = 2'b00;
        rxb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rxb_data = DW'($urandom_range(0, 511));
            cyc("t5_rxfill");
        end
        rxb_valid = 1'b0;
        gp0_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gp0_wdata = DW'($urandom_range(0, 511));
            cyc("t5_txfill");
        end
        gp0_clr = 2'b01;
        gp0_wdata = 9'h123;
        cyc("t5_clr");
        gp0_clr = 2'b00;
        gp0_wr = 1'b0;
        chk("t5_tx_cnt", 32'(gp0_tx_cnt), 32'd0);
        chk("t5_tx_empty", 32'(txb_empty), 32'd1);
        chk("t5_tx_flags", 32'(gp0_stat[5:4]), 32'd0);
        chk("t5_rx_cnt", 32'(gp0_rx_cnt), 32'd5);

        // 6: thresholds - TX aempty at 2/3, RX afull at 11/12
        gp0_wr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            gp0_wdata = DW'($urandom_range(0, 511));
            cyc("t6_txth");
            if (i == 2) chk("t6_aempty_at2", 32'(txb_aempty), 32'd1);
            if (i == 3) chk("t6_aempty_at3", 32'(txb_aempty), 32'd0);
        end
        gp0_wr = 1'b0;
        rxb_valid = 1'b1;
        for (int i = 6; i <= 12; i++) begin
            rxb_data = DW'($urandom_range(0, 511));
            cyc("t6_rxth");
            if (i == 11) chk("t6_afull_at11", 32'(rxb_afull), 32'd0);
            if (i == 12) chk("t6_afull_at12", 32'(rxb_afull), 32'd1);
        end
        rxb_valid = 1'b0;

        // 6: 40 write/read pairs on TX wrap the pointers more than twice
        gp0_wr = 1'b1;
        txb_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gp0_wdata = DW'($urandom_range(0, 511));
            cyc("t6_pairs");
        end

        // Random traffic on both channels
        for (int i = 0; i < 300; i++) begin
            gp0_wr    = 1'($urandom_range(0, 1));
            gp0_wdata = DW'($urandom_range(0, 511));
            txb_req   = 1'($urandom_range(0, 1));
            rxb_valid = 1'($urandom_range(0, 1));
            rxb_data  = DW'($urandom_range(0, 511));
            gp0_rd    = 1'($urandom_range(0, 1));
            gp0_clr   = ($urandom_range(0, 63) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc("rand");
        end
        gp0_clr = 2'b00;

        // Asynchronous reset mid-stream
        gp0_wr = 1'b1; txb_req = 1'b1; rxb_valid = 1'b1; gp0_rd = 1'b1;
        cyc("pre_rst");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2 rst = 1'b1;
        gp0_wr = 1'b0; txb_req = 1'b0; rxb_valid = 1'b0; gp0_rd = 1'b0;
        cyc("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
